// File: rtl/mainfsm.sv
// mainfsm -- Moore control FSM sequencing the multicycle ARM datapath
// through fetch, decode, execute, memory and writeback steps.
//
// Ports:
//   clk        rising-edge clock
//   reset      synchronous, active-high; forces FETCH
//   Op[1:0]    instruction class (00 DP, 01 mem, 10 branch, 11 undefined)
//   Funct[5:0] Instr[25:20]; [5]=I, [0]=L for memory ops
//   IRWrite, AdrSrc, ALUSrcA[1:0], ALUSrcB[1:0], ResultSrc[1:0], ALUOp,
//   NextPC     datapath control, pure function of state
//   RegW, MemW, Branch   write requests, not yet gated by the condition check
//   state_o    current state encoding for debug/trace
//
// Optional feature macro: FSM_NOWB_EN
//   When defined, compare-class data-processing (Funct[4:3]=2'b10) returns
//   from EXECUTER/EXECUTEI straight to FETCH, skipping ALUWB.

module mainfsm #(
    parameter int unsigned STATE_W = 4
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [1:0]         Op,
    input  logic [5:0]         Funct,
    output logic               IRWrite,
    output logic               AdrSrc,
    output logic [1:0]         ALUSrcA,
    output logic [1:0]         ALUSrcB,
    output logic [1:0]         ResultSrc,
    output logic               ALUOp,
    output logic               NextPC,
    output logic               RegW,
    output logic               MemW,
    output logic               Branch,
    output logic [STATE_W-1:0] state_o
);

    typedef enum logic [STATE_W-1:0] {
        FETCH    = 0,
        DECODE   = 1,
        MEMADR   = 2,
        MEMRD    = 3,
        MEMWB    = 4,
        MEMWR    = 5,
        EXECUTER = 6,
        EXECUTEI = 7,
        ALUWB    = 8,
        BRANCH   = 9,
        UNKNOWN  = 10
    } state_t;

    typedef struct packed {
        logic       ir_write;
        logic       adr_src;
        logic [1:0] alu_src_a;
        logic [1:0] alu_src_b;
        logic [1:0] result_src;
        logic       alu_op;
        logic       next_pc;
        logic       reg_w;
        logic       mem_w;
        logic       branch;
    } ctrl_t;

    state_t state_q, state_d;
    ctrl_t  ctrl_q;

    // Funct[2:1] never steers the sequence; [4:3] only with FSM_NOWB_EN.
    logic unused_funct;
    assign unused_funct = ^Funct[4:1];

    // Control word for a given state. UNKNOWN and any illegal encoding
    // fall to the all-zero default.
    function automatic ctrl_t ctrl_of(input state_t s);
        ctrl_t c;
        c = '0;
        case (s)
            FETCH: begin
                c.alu_src_a  = 2'b01;
                c.alu_src_b  = 2'b10;
                c.result_src = 2'b10;
                c.ir_write   = 1'b1;
                c.next_pc    = 1'b1;
            end
            DECODE: begin
                c.alu_src_a  = 2'b01;
                c.alu_src_b  = 2'b10;
                c.result_src = 2'b10;
            end
            MEMADR: begin
                c.alu_src_b  = 2'b01;
            end
            MEMRD: begin
                c.adr_src    = 1'b1;
            end
            MEMWB: begin
                c.result_src = 2'b01;
                c.reg_w      = 1'b1;
            end
            MEMWR: begin
                c.adr_src    = 1'b1;
                c.mem_w      = 1'b1;
            end
            EXECUTER: begin
                c.alu_op     = 1'b1;
            end
            EXECUTEI: begin
                c.alu_src_b  = 2'b01;
                c.alu_op     = 1'b1;
            end
            ALUWB: begin
                c.reg_w      = 1'b1;
            end
            BRANCH: begin
                c.alu_src_b  = 2'b01;
                c.result_src = 2'b10;
                c.branch     = 1'b1;
            end
            default: c = '0;
        endcase
        return c;
    endfunction

    always_comb begin
        state_d = FETCH;
        case (state_q)
            FETCH:  state_d = DECODE;
            DECODE: begin
                case (Op)
                    2'b00:   state_d = Funct[5] ? EXECUTEI : EXECUTER;
                    2'b01:   state_d = MEMADR;
                    2'b10:   state_d = BRANCH;
                    default: state_d = UNKNOWN;
                endcase
            end
            MEMADR: state_d = Funct[0] ? MEMRD : MEMWR;
            MEMRD:  state_d = MEMWB;
            EXECUTER, EXECUTEI: begin
`ifdef FSM_NOWB_EN
                state_d = (Funct[4:3] == 2'b10) ? FETCH : ALUWB;
`else
                state_d = ALUWB;
`endif
            end
            // MEMWB, MEMWR, ALUWB, BRANCH, UNKNOWN and illegal codes
            default: state_d = FETCH;
        endcase
    end

    // Outputs are registered alongside the state by decoding the next
    // state, so they stay a pure function of state_q with no comb path.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= FETCH;
            ctrl_q  <= ctrl_of(FETCH);
        end else begin
            state_q <= state_d;
            ctrl_q  <= ctrl_of(state_d);
        end
    end

    assign IRWrite   = ctrl_q.ir_write;
    assign AdrSrc    = ctrl_q.adr_src;
    assign ALUSrcA   = ctrl_q.alu_src_a;
    assign ALUSrcB   = ctrl_q.alu_src_b;
    assign ResultSrc = ctrl_q.result_src;
    assign ALUOp     = ctrl_q.alu_op;
    assign NextPC    = ctrl_q.next_pc;
    assign RegW      = ctrl_q.reg_w;
    assign MemW      = ctrl_q.mem_w;
    assign Branch    = ctrl_q.branch;
    assign state_o   = state_q;

endmodule

// File: tb/tb_mainfsm.sv
// Testbench for mainfsm: expected states are queued as each instruction
// is driven and compared, with the expected control word, as the FSM
// steps through them.

module tb_mainfsm;

    logic       clk = 1'b0;
    logic       reset;
    logic [1:0] Op;
    logic [5:0] Funct;
    logic       IRWrite, AdrSrc, ALUOp, NextPC, RegW, MemW, Branch;
    logic [1:0] ALUSrcA, ALUSrcB, ResultSrc;
    logic [3:0] state_o;

    int unsigned n_checks = 0;
    int unsigned n_errors = 0;
    int          sb_q[$];
    bit          ldr_regw_seen;

    mainfsm #(.STATE_W(4)) dut (
        .clk       (clk),
        .reset     (reset),
        .Op        (Op),
        .Funct     (Funct),
        .IRWrite   (IRWrite),
        .AdrSrc    (AdrSrc),
        .ALUSrcA   (ALUSrcA),
        .ALUSrcB   (ALUSrcB),
        .ResultSrc (ResultSrc),
        .ALUOp     (ALUOp),
        .NextPC    (NextPC),
        .RegW      (RegW),
        .MemW      (MemW),
        .Branch    (Branch),
        .state_o   (state_o)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: act=timeout exp=finish");
        $fatal(1, "watchdog expired");
    end

    task automatic check_eq(input string tag, input logic [31:0] act,
                            input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: act=%0h exp=%0h", tag, act, exp);
        end
    endtask

    // {IRWrite,AdrSrc,ALUSrcA,ALUSrcB,ResultSrc,ALUOp,NextPC,RegW,MemW,Branch}
    function automatic logic [12:0] exp_ctrl(input int s);
        case (s)
            0:       return 13'b1_0_01_10_10_0_1_000;
            1:       return 13'b0_0_01_10_10_0_0_000;
            2:       return 13'b0_0_00_01_00_0_0_000;
            3:       return 13'b0_1_00_00_00_0_0_000;
            4:       return 13'b0_0_00_00_01_0_0_100;
            5:       return 13'b0_1_00_00_00_0_0_010;
            6:       return 13'b0_0_00_00_00_1_0_000;
            7:       return 13'b0_0_00_01_00_1_0_000;
            8:       return 13'b0_0_00_00_00_0_0_100;
            9:       return 13'b0_0_00_01_10_0_0_001;
            default: return 13'b0;
        endcase
    endfunction

    // Independent path model: states visited after FETCH, ending in FETCH.
    function automatic void push_path(input logic [1:0] op, input logic [5:0] f);
        case (op)
            2'b00: begin
                sb_q.push_back(1);
                sb_q.push_back(f[5] ? 7 : 6);
`ifdef FSM_NOWB_EN
                if (f[4:3] != 2'b10) sb_q.push_back(8);
`else
                sb_q.push_back(8);
`endif
            end
            2'b01: begin
                sb_q.push_back(1);
                sb_q.push_back(2);
                sb_q.push_back(f[0] ? 3 : 5);
                if (f[0]) sb_q.push_back(4);
            end
            2'b10: begin sb_q.push_back(1); sb_q.push_back(9); end
            default: begin sb_q.push_back(1); sb_q.push_back(10); end
        endcase
        sb_q.push_back(0);
    endfunction

    task automatic step_and_check(input string tag);
        int exp_s;
        logic [12:0] act_c;
        @(posedge clk);
        #1;
        exp_s = sb_q.pop_front();
        act_c = {IRWrite, AdrSrc, ALUSrcA, ALUSrcB, ResultSrc, ALUOp,
                 NextPC, RegW, MemW, Branch};
        check_eq({tag, "_state"}, 32'(state_o), 32'(exp_s));
        check_eq({tag, "_ctrl"}, 32'(act_c), 32'(exp_ctrl(exp_s)));
        check_eq({tag, "_nox"}, 32'($isunknown(act_c)), 32'd0);
        check_eq({tag, "_wr1hot"}, 32'($countones({RegW, MemW, Branch}) <= 1), 32'd1);
        if (IRWrite === 1'b1)
            check_eq({tag, "_irw"}, 32'(state_o), 32'd0);
    endtask

    task automatic drain(input string tag);
        int budget = 16;
        while (sb_q.size() > 0 && budget > 0) begin
            step_and_check(tag);
            budget--;
        end
        check_eq({tag, "_drained"}, 32'(sb_q.size()), 32'd0);
        sb_q.delete();
    endtask

    task automatic run_instr(input string tag, input logic [1:0] op,
                             input logic [5:0] f);
        Op = op;
        Funct = f;
        push_path(op, f);
        drain(tag);
    endtask

    initial begin
        reset = 1'b1;
        Op    = 2'b11;
        Funct = 6'b111111;
        @(posedge clk);
        sb_q.push_back(0);
        drain("reset");
        reset = 1'b0;

        // Directed paths with explicit expected state sequences.
        Op = 2'b01; Funct = 6'b011001;                       // LDR
        sb_q = '{1, 2, 3, 4, 0};
        drain("ldr");
        Op = 2'b01; Funct = 6'b011000;                       // STR
        sb_q = '{1, 2, 5, 0};
        drain("str");
        Op = 2'b00; Funct = 6'b101000;                       // ADD imm
        sb_q = '{1, 7, 8, 0};
        drain("addi");
        Op = 2'b00; Funct = 6'b010101;                       // CMP reg
`ifdef FSM_NOWB_EN
        sb_q = '{1, 6, 0};
`else
        sb_q = '{1, 6, 8, 0};
`endif
        drain("cmp");
        Op = 2'b10; Funct = 6'b000000;                       // B
        sb_q = '{1, 9, 0};
        drain("branch");
        Op = 2'b11; Funct = 6'b000000;                       // undefined
        sb_q = '{1, 10, 0};
        drain("undef");

        // Reset while an LDR sits in MEMRD: no register write may follow.
        Op = 2'b01; Funct = 6'b011001;
        sb_q = '{1, 2, 3};
        drain("ldr_pre_rst");
        reset = 1'b1;
        sb_q = '{0};
        drain("ldr_rst");
        reset = 1'b0;
        Op = 2'b10; Funct = 6'b000000;
        ldr_regw_seen = 1'b0;
        sb_q = '{1, 9, 0};
        while (sb_q.size() > 0) begin
            step_and_check("after_rst");
            if (RegW === 1'b1) ldr_regw_seen = 1'b1;
        end
        check_eq("ldr_abandoned_regw", 32'(ldr_regw_seen), 32'd0);

        // Inputs changed in MEMRD must not alter the remaining path.
        Op = 2'b01; Funct = 6'b011001;
        sb_q = '{1, 2, 3};
        drain("ldr_toggle_a");
        Op = 2'b10; Funct = 6'b100000;
        sb_q = '{4, 0};
        drain("ldr_toggle_b");

        // Random instruction mix against the path model.
        for (int i = 0; i < 40; i++)
            run_instr("rand", 2'($urandom_range(0, 3)), 6'($urandom));

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/mainfsm.md
Name: mainfsm

Overview:
- Moore control state machine that sequences the multicycle ARM datapath: fetch, decode, execute, memory and writeback steps.
- Drives the datapath multiplexer selects and write enables from the decoded instruction class (Op, Funct).
- Sits inside the controller beside the ALU decoder and the condition logic.
- Its RegW, MemW and Branch/NextPC requests are unconditioned; downstream logic gates them with the condition-check result (CondEx) and applies flag-register updates.

Parameters:
STATE_W  4  width of the state register; must be ≥4 to hold the 11 states.

Ports:
clk        input   1  system clock, rising edge
reset      input   1  synchronous, active-high reset
Op         input   2  instruction class: 00 data-processing, 01 memory, 10 branch, 11 undefined
Funct      input   6  Instr[25:20]; Funct[5]=I (immediate), Funct[0]=S/L (load when memory)
IRWrite    output  1  instruction register write enable
AdrSrc     output  1  memory address select: 0 PC, 1 ALUOut
ALUSrcA    output  2  ALU A select: 00 register A, 01 PC
ALUSrcB    output  2  ALU B select: 00 register WriteData, 01 ExtImm, 10 constant 4
ResultSrc  output  2  result select: 00 ALUOut, 01 Data, 10 ALUResult
ALUOp      output  1  1 = ALU decoder uses Funct; 0 = force ADD
NextPC     output  1  unconditional PC write request
RegW       output  1  register write request (pre-condition)
MemW       output  1  memory write request (pre-condition)
Branch     output  1  branch PC write request (pre-condition)
state_o    output  STATE_W  current state encoding, for debug and trace

Behaviour:
- States and encodings: FETCH=0, DECODE=1, MEMADR=2, MEMRD=3, MEMWB=4, MEMWR=5, EXECUTER=6, EXECUTEI=7, ALUWB=8, BRANCH=9, UNKNOWN=10.
- Encodings 11-15 are illegal and behave exactly as UNKNOWN.
- Reset: on a clk edge with reset=1, the state becomes FETCH; this overrides any transition.
- Reset mid-instruction abandons that instruction with no further writes. Outputs after reset equal the FETCH outputs.
- Transitions, one per clk:
  - FETCH -> DECODE
  - DECODE: Op=00 & Funct[5]=0 -> EXECUTER; Op=00 & Funct[5]=1 -> EXECUTEI; Op=01 -> MEMADR; Op=10 -> BRANCH; Op=11 -> UNKNOWN.
  - MEMADR: Funct[0]=1 -> MEMRD, else MEMWR.
  - MEMRD -> MEMWB -> FETCH
  - MEMWR -> FETCH
  - EXECUTER or EXECUTEI -> ALUWB -> FETCH
  - BRANCH -> FETCH
  - UNKNOWN -> FETCH
- Op and Funct are sampled only in DECODE and MEMADR; changes in other states have no effect.
- Outputs are a pure function of the state (Moore, no input dependence). Any output not listed for a state is 0:
  - FETCH: AdrSrc=0, ALUSrcA=01, ALUSrcB=10, ALUOp=0, ResultSrc=10, IRWrite=1, NextPC=1
  - DECODE: ALUSrcA=01, ALUSrcB=10, ALUOp=0, ResultSrc=10
  - MEMADR: ALUSrcA=00, ALUSrcB=01, ALUOp=0
  - MEMRD: AdrSrc=1, ResultSrc=00
  - MEMWB: ResultSrc=01, RegW=1
  - MEMWR: AdrSrc=1, ResultSrc=00, MemW=1
  - EXECUTER: ALUSrcA=00, ALUSrcB=00, ALUOp=1
  - EXECUTEI: ALUSrcA=00, ALUSrcB=01, ALUOp=1
  - ALUWB: ResultSrc=00, RegW=1
  - BRANCH: ALUSrcA=00, ALUSrcB=01, ALUOp=0, ResultSrc=10, Branch=1
  - UNKNOWN: all outputs 0
- Instruction latency from FETCH through the last state:
  - LDR: 5 cycles
  - STR: 4 cycles
  - data-processing: 4 cycles
  - branch: 3 cycles
  - undefined: 3 cycles
- Invariants:
  - At most one of RegW, MemW, Branch is 1 in any cycle.
  - IRWrite=1 only in FETCH.
  - No X on any output in any state, legal or illegal.

Optional Feature:
FSM_NOWB_EN:
- Defined: from EXECUTER or EXECUTEI, if Funct[4:3]=2'b10 (TST/TEQ/CMP/CMN), the next state is FETCH and ALUWB is skipped. Compare-class data-processing then takes 3 cycles.
- Undefined: EXECUTER/EXECUTEI always go to ALUWB; RegW suppression for compares is left to downstream decode.

Test Plan:
- reset=1 for 2 cycles, then 0 -> state_o=0, IRWrite=1, NextPC=1, ALUSrcB=10 in the first cycle after reset; state_o=1 the next cycle.
- Op=01, Funct=6'b011001 (LDR) -> states 0,1,2,3,4,0; RegW=1 only in state 4; ResultSrc=01 there.
- Op=01, Funct=6'b011000 (STR) -> states 0,1,2,5,0; MemW=1 only in state 5, AdrSrc=1.
- Op=00, Funct=6'b101000 (ADD imm) -> 0,1,7,8,0 with ALUOp=1, ALUSrcB=01 in 7. Repeat with Funct=6'b010101 (CMP reg): without FSM_NOWB_EN -> 0,1,6,8,0; with it -> 0,1,6,0.
- Op=10 -> 0,1,9,0 with Branch=1, ALUSrcB=01 in 9. Op=11 -> 0,1,10,0 with all outputs 0 in 10.
- reset asserted while in state 3 (LDR mid-flight) -> next state 0, RegW never asserted for that LDR. Toggling Op in state 3 with reset=0 does not change the path.
